// File: rtl/izh_step_scheduler_if.sv
// Host/neuron-tile signal bundle for the Izhikevich timestep scheduler.
// The slave side is the scheduler; the master side is the tile/host driving it.
interface izh_step_scheduler_if #(
    parameter int NEURON_ADR = 4,
    parameter int N_IN       = 32,
    parameter int CNT_W      = 16
);
    logic                  START;
    logic [N_IN-1:0]       SPIKE_VEC;
    logic                  CFG_WE;
    logic [NEURON_ADR:0]   CFG_ADDR;
    logic [31:0]           CFG_DATA;
    logic                  CFG_READY;
    logic                  CFG_ERR;
    logic                  WE;
    logic [NEURON_ADR:0]   A;
    logic [31:0]           DI;
    logic [NEURON_ADR:0]   DPRA;
    logic                  EN;
    logic                  STEP;
    logic                  SPIKE_IN;
    logic                  SPIKE_OUT;
    logic                  BUSY;
    logic                  DONE;
    logic [CNT_W-1:0]      STEP_COUNT;

    modport slave (
        input  START, SPIKE_VEC, CFG_WE, CFG_ADDR, CFG_DATA, SPIKE_IN,
        output CFG_READY, CFG_ERR, WE, A, DI, DPRA, EN, STEP,
        output SPIKE_OUT, BUSY, DONE, STEP_COUNT
    );

    modport master (
        output START, SPIKE_VEC, CFG_WE, CFG_ADDR, CFG_DATA, SPIKE_IN,
        input  CFG_READY, CFG_ERR, WE, A, DI, DPRA, EN, STEP,
        input  SPIKE_OUT, BUSY, DONE, STEP_COUNT
    );
endinterface

// File: rtl/izh_step_scheduler.sv
// Timestep controller for one Izhikevich tile: weight loading while idle, then
// presynaptic scan, neuron step, spike-latency wait and completion report.
module izh_step_scheduler #(
    parameter int NEURON_ADR = 4,
    parameter int N_IN       = 32,
    parameter int SPIKE_LAT  = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    izh_step_scheduler_if.slave  bus
);
    localparam int AW    = NEURON_ADR + 1;
    localparam int LAT_W = (SPIKE_LAT > 1) ? $clog2(SPIKE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_DRAIN, S_STEPS, S_WAIT, S_FIN
    } state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     idx;
    logic [N_IN-1:0]   spk;
    logic [N_IN-1:0]   spk_sh;
    logic              en_r;
    logic [LAT_W-1:0]  wcnt;
    logic              we_r;
    logic [AW-1:0]     a_r;
    logic [31:0]       di_r;
    logic              err_r;
    logic              spike_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              accept, scan_last, wait_last;

    // A simultaneous config write wins over START; the START is simply lost.
    assign accept    = (state == S_IDLE) && bus.START && !bus.CFG_WE;
    assign scan_last = (idx == AW'(N_IN - 1));
    assign wait_last = (wcnt == '0);
    assign spk_sh    = spk >> 1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)    state_nxt = S_SCAN;
            S_SCAN:  if (scan_last) state_nxt = S_DRAIN;
            S_DRAIN:                state_nxt = S_STEPS;
            S_STEPS:                state_nxt = S_WAIT;
            S_WAIT:  if (wait_last) state_nxt = S_FIN;
            S_FIN:                  state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Scan: DPRA is idx itself; the latched vector shifts so bit 0 is always
    // the enable for the address being presented.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idx  <= '0;
            spk  <= '0;
            en_r <= 1'b0;
        end else if (accept) begin
            idx  <= '0;
            spk  <= bus.SPIKE_VEC;
            en_r <= bus.SPIKE_VEC[0];
        end else if (state == S_SCAN) begin
            if (scan_last) begin
                idx  <= '0;
                en_r <= 1'b0;
            end else begin
                idx  <= idx + AW'(1);
                spk  <= spk_sh;
                en_r <= spk_sh[0];
            end
        end
    end

    // Spike-latency wait and completion bookkeeping on the edge entering FIN.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wcnt    <= '0;
            spike_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            if (state == S_STEPS)
                wcnt <= LAT_W'(SPIKE_LAT - 1);
            else if (state == S_WAIT && !wait_last)
                wcnt <= wcnt - LAT_W'(1);
            if (state == S_WAIT && wait_last) begin
                spike_r <= bus.SPIKE_IN;
                cnt_r   <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Host weight port: registered pass-through in IDLE, sticky error otherwise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            we_r  <= 1'b0;
            a_r   <= '0;
            di_r  <= '0;
            err_r <= 1'b0;
        end else if (state == S_IDLE) begin
            we_r <= bus.CFG_WE;
            if (bus.CFG_WE) begin
                a_r  <= bus.CFG_ADDR;
                di_r <= bus.CFG_DATA;
            end
        end else begin
            we_r <= 1'b0;
            if (bus.CFG_WE) err_r <= 1'b1;
        end
    end

    assign bus.BUSY       = (state != S_IDLE);
    assign bus.CFG_READY  = (state == S_IDLE);
    assign bus.STEP       = (state == S_STEPS);
    assign bus.DONE       = (state == S_FIN);
    assign bus.DPRA       = idx;
    assign bus.EN         = en_r;
    assign bus.WE         = we_r;
    assign bus.A          = a_r;
    assign bus.DI         = di_r;
    assign bus.CFG_ERR    = err_r;
    assign bus.SPIKE_OUT  = spike_r;
    assign bus.STEP_COUNT = cnt_r;
endmodule

// File: tb/tb_izh_step_scheduler.sv
// Directed bench for izh_step_scheduler: config table, exact scan schedule,
// spike capture, ignored/dropped STARTs, mid-scan reset and counter wrap.
module tb_izh_step_scheduler;
    localparam int NEURON_ADR = 4;
    localparam int N_IN       = 32;
    localparam int SPIKE_LAT  = 2;
    localparam int CNT_W      = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic fire = 1'b0;
    logic st_d1 = 1'b0, st_d2 = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    izh_step_scheduler_if #(.NEURON_ADR(NEURON_ADR), .N_IN(N_IN), .CNT_W(CNT_W)) bus ();

    izh_step_scheduler #(
        .NEURON_ADR(NEURON_ADR), .N_IN(N_IN), .SPIKE_LAT(SPIKE_LAT), .CNT_W(CNT_W)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Neuron model: registered spike appears exactly two cycles after STEP.
    always @(posedge CLK) begin
        st_d1 <= bus.STEP;
        st_d2 <= st_d1;
    end
    assign bus.SPIKE_IN = st_d2 & fire;

    always @(negedge CLK) if (bus.DONE) done_cnt <= done_cnt + 1;

    typedef struct {
        logic        start;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_di;
        logic        e_busy;
    } cfg_vec_t;

    cfg_vec_t tbl [5];

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic start_step(input logic [31:0] vec, input logic f);
        bus.SPIKE_VEC = vec;
        fire          = f;
        bus.START     = 1'b1;
        tick();
        bus.START     = 1'b0;
        check("busy_rise", bus.BUSY, 1);
    endtask

    task automatic wait_done(input string nm, input logic exp_sp);
        int n;
        n = 0;
        while (!bus.DONE && n < 100) begin
            tick();
            n++;
        end
        check({nm, "_done"}, bus.DONE, 1);
        check({nm, "_spike"}, bus.SPIKE_OUT, exp_sp);
        tick();
        check({nm, "_idle_busy"}, bus.BUSY, 0);
    endtask

    initial begin
        int d0;
        tbl[0] = '{1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h11, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 5'd4, 32'h22, 1'b1, 5'd4, 32'h22, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 5'd9, 32'h99, 1'b0, 5'd4, 32'h22, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 5'd7, 32'h33, 1'b1, 5'd7, 32'h33, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 5'd0, 32'h00, 1'b0, 5'd7, 32'h33, 1'b0};

        bus.START = 0; bus.SPIKE_VEC = '0; bus.CFG_WE = 0; bus.CFG_ADDR = '0; bus.CFG_DATA = '0;
        @(negedge CLK); @(negedge CLK);
        check("rst_ready", bus.CFG_READY, 1);
        check("rst_busy", bus.BUSY, 0);
        check("rst_we", bus.WE, 0);
        check("rst_dpra", bus.DPRA, 0);
        check("rst_en", bus.EN, 0);
        check("rst_done", bus.DONE, 0);
        check("rst_count", bus.STEP_COUNT, 0);
        RST = 1'b1;
        tick();

        // Config table, including START+CFG_WE (write wins, no timestep)
        for (int i = 0; i < 5; i++) begin
            bus.START    = tbl[i].start;
            bus.CFG_WE   = tbl[i].we;
            bus.CFG_ADDR = tbl[i].addr;
            bus.CFG_DATA = tbl[i].data;
            tick();
            check($sformatf("cfg%0d_we", i), bus.WE, tbl[i].e_we);
            check($sformatf("cfg%0d_a", i), bus.A, tbl[i].e_a);
            check($sformatf("cfg%0d_di", i), bus.DI, tbl[i].e_di);
            check($sformatf("cfg%0d_busy", i), bus.BUSY, tbl[i].e_busy);
        end
        bus.START = 0; bus.CFG_WE = 0;
        tick();
        check("cfg_nostart_busy", bus.BUSY, 0);

        // Sparse scan with exact schedule; START during WAIT is ignored
        d0 = done_cnt;
        start_step(32'h8000_0005, 1'b1);
        for (int i = 0; i < N_IN; i++) begin
            check($sformatf("scan_dpra%0d", i), bus.DPRA, i);
            check($sformatf("scan_en%0d", i), bus.EN, (i == 0 || i == 2 || i == 31));
            tick();
        end
        check("drain_en", bus.EN, 0);
        check("drain_dpra", bus.DPRA, 0);
        check("drain_step", bus.STEP, 0);
        tick();
        check("step_k34", bus.STEP, 1);
        tick();
        check("wait1_step", bus.STEP, 0);
        bus.START = 1'b1;
        tick();
        check("wait2_done", bus.DONE, 0);
        bus.START = 1'b0;
        tick();
        check("done_k37", bus.DONE, 1);
        check("spike_out1", bus.SPIKE_OUT, 1);
        check("count1", bus.STEP_COUNT, 1);
        tick();
        check("after_fin_busy", bus.BUSY, 0);
        check("after_fin_ready", bus.CFG_READY, 1);
        tick(); tick();
        check("one_done", done_cnt - d0, 1);
        check("no_restart", bus.BUSY, 0);

        // Non-firing step with an illegal config write during SCAN
        start_step(32'h0000_00F0, 1'b0);
        bus.CFG_WE = 1'b1; bus.CFG_ADDR = 5'd9; bus.CFG_DATA = 32'h55;
        tick();
        bus.CFG_WE = 1'b0;
        check("scan_cfg_we", bus.WE, 0);
        check("scan_cfg_err", bus.CFG_ERR, 1);
        check("scan_cfg_a_hold", bus.A, 7);
        wait_done("nofire", 1'b0);
        check("count2", bus.STEP_COUNT, 2);
        check("err_sticky", bus.CFG_ERR, 1);

        // Asynchronous reset mid-SCAN
        start_step(32'hFFFF_FFFF, 1'b1);
        tick(); tick();
        d0 = done_cnt;
        RST = 1'b0;
        #1;
        check("mrst_busy", bus.BUSY, 0);
        check("mrst_ready", bus.CFG_READY, 1);
        check("mrst_en", bus.EN, 0);
        check("mrst_dpra", bus.DPRA, 0);
        check("mrst_count", bus.STEP_COUNT, 0);
        check("mrst_err", bus.CFG_ERR, 0);
        check("mrst_spike", bus.SPIKE_OUT, 0);
        tick();
        RST = 1'b1;
        for (int i = 0; i < 45; i++) tick();
        check("mrst_no_done", done_cnt - d0, 0);
        check("mrst_count_hold", bus.STEP_COUNT, 0);

        // Counter wrap: 17 timesteps on a 4-bit counter
        for (int s = 0; s < 17; s++) begin
            start_step(32'h0000_0001 << s, s[0]);
            wait_done($sformatf("wrap%0d", s), s[0]);
        end
        check("wrap_count", bus.STEP_COUNT, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
